// File: rtl/dbus_uncached_responder_if.sv
// Uncached data-bus request/response pair plus the single-beat AXI channels it maps onto.
// slave is the responder's view; master is the datapath-plus-crossbar view.
interface dbus_uncached_responder_if #(
    parameter int ID_W = 4
) ();
    logic            req_valid;
    logic [31:0]     req_addr;
    logic [1:0]      req_size;
    logic [3:0]      req_strobe;
    logic [31:0]     req_data;
    logic            addr_ok;
    logic            data_ok;
    logic [31:0]     resp_data;
    logic            resp_err;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [2:0]      arsize;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [2:0]      awsize;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output addr_ok, data_ok, resp_data, resp_err,
        output arid, araddr, arsize, arlen, arburst, arvalid,
        input  arready, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awsize, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready, bresp, bvalid,
        output bready
    );

    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  addr_ok, data_ok, resp_data, resp_err,
        input  arid, araddr, arsize, arlen, arburst, arvalid,
        output arready, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awsize, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dbus_uncached_responder.sv
// Turns one uncached data-bus request at a time into a single-beat AXI read or write.
// Read: IDLE -> RD_A -> RD_D -> IDLE.  Write: IDLE -> WR_AW -> WR_B -> IDLE.
module dbus_uncached_responder #(
    parameter int unsigned        ID_W   = 4,
    parameter logic [ID_W-1:0]    AXI_ID = 4'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    dbus_uncached_responder_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWrAw, StWrB} state_e;

    state_e      stateQ, stateD;
    logic [31:0] addrQ, dataQ, respDataQ;
    logic [1:0]  sizeQ;
    logic [3:0]  strbQ;
    logic        awDoneQ, wDoneQ, dataOkQ, respErrQ;
    logic        accept, awHs, wHs, rHs, bHs;
    logic        unusedRlast;

    assign accept      = bus.addr_ok;
    assign awHs        = bus.awvalid && bus.awready;
    assign wHs         = bus.wvalid && bus.wready;
    assign rHs         = bus.rready && bus.rvalid;
    assign bHs         = bus.bready && bus.bvalid;
    assign unusedRlast = bus.rlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: if (accept) stateD = (bus.req_strobe == 4'b0000) ? StRdA : StWrAw;
            StRdA:  if (bus.arready) stateD = StRdD;
            StRdD:  if (bus.rvalid) stateD = StIdle;
            // AW and W may complete in either order or together
            StWrAw: if ((awDoneQ || awHs) && (wDoneQ || wHs)) stateD = StWrB;
            StWrB:  if (bus.bvalid) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        bus.addr_ok = 1'b0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        unique case (stateQ)
            StIdle: bus.addr_ok = bus.req_valid && !reset;
            StRdA:  bus.arvalid = 1'b1;
            StRdD:  bus.rready  = 1'b1;
            StWrAw: begin
                bus.awvalid = !awDoneQ;
                bus.wvalid  = !wDoneQ;
            end
            StWrB:  bus.bready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addrQ     <= 32'd0;
            dataQ     <= 32'd0;
            sizeQ     <= 2'd0;
            strbQ     <= 4'd0;
            awDoneQ   <= 1'b0;
            wDoneQ    <= 1'b0;
            dataOkQ   <= 1'b0;
            respDataQ <= 32'd0;
            respErrQ  <= 1'b0;
        end else begin
            dataOkQ <= rHs || bHs;
            if (accept) begin
                addrQ   <= bus.req_addr;
                dataQ   <= bus.req_data;
                sizeQ   <= bus.req_size;
                strbQ   <= bus.req_strobe;
                awDoneQ <= 1'b0;
                wDoneQ  <= 1'b0;
            end
            if (awHs) awDoneQ <= 1'b1;
            if (wHs)  wDoneQ  <= 1'b1;
            if (rHs) begin
                respDataQ <= bus.rdata;
                respErrQ  <= (bus.rresp != 2'b00);
            end
            if (bHs) respErrQ <= (bus.bresp != 2'b00);
        end
    end

    assign bus.data_ok   = dataOkQ;
    assign bus.resp_data = respDataQ;
    assign bus.resp_err  = respErrQ;

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = addrQ;
    assign bus.arsize  = {1'b0, sizeQ};
    assign bus.arlen   = 8'd0;
    assign bus.arburst = 2'b01;

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addrQ;
    assign bus.awsize  = {1'b0, sizeQ};
    assign bus.awlen   = 8'd0;
    assign bus.awburst = 2'b01;
    assign bus.wdata   = dataQ;
    assign bus.wstrb   = strbQ;
    assign bus.wlast   = 1'b1;
endmodule

// File: tb/tb_dbus_uncached_responder.sv
// Bench for dbus_uncached_responder: directed table, reset/back-to-back sequences,
// then random transactions against an AXI slave model with random latencies.
module tb_dbus_uncached_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dbus_uncached_responder_if #(.ID_W(4)) bus ();

    dbus_uncached_responder #(.ID_W(4), .AXI_ID(4'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] modelData = 32'd0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
        int          axDelay;
        int          wDelay;
        int          respDelay;
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          chain;
        logic [31:0] expData;
        bit          expErr;
        logic [2:0]  expAxSize;
    } vec_t;

    function automatic vec_t mkv(logic [31:0] addr, logic [1:0] size, logic [3:0] strobe,
                                 logic [31:0] data, int axD, int wD, int rD, logic [31:0] rdata,
                                 logic [1:0] resp, bit chain, logic [31:0] expData, bit expErr,
                                 logic [2:0] expAxSize);
        vec_t v;
        v.addr = addr; v.size = size; v.strobe = strobe; v.data = data;
        v.axDelay = axD; v.wDelay = wD; v.respDelay = rD; v.rdata = rdata; v.resp = resp;
        v.chain = chain; v.expData = expData; v.expErr = expErr; v.expAxSize = expAxSize;
        return v;
    endfunction

    function automatic vec_t genRand();
        vec_t v;
        v.addr      = $urandom;
        v.size      = 2'($urandom_range(0, 2));
        v.strobe    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
        v.data      = $urandom;
        v.axDelay   = $urandom_range(0, 3);
        v.wDelay    = $urandom_range(0, 3);
        v.respDelay = $urandom_range(0, 3);
        v.rdata     = $urandom;
        v.resp      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        v.chain     = 1'b0;
        v.expData   = 32'd0;
        v.expErr    = 1'b0;
        v.expAxSize = {1'b0, v.size};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic axiIdle();
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00;
        bus.rlast = 1'b1;   bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid = 1'b0;  bus.bresp = 2'b00;
    endtask

    task automatic driveReq(input vec_t v);
        bus.req_valid = 1'b1; bus.req_addr = v.addr; bus.req_size = v.size;
        bus.req_strobe = v.strobe; bus.req_data = v.data;
    endtask

    // While chained, keep a changing request on the bus that must be ignored
    task automatic busyReq(input bit chain);
        if (chain) begin
            bus.req_valid = 1'b1; bus.req_addr = $urandom; bus.req_size = 2'($urandom_range(0, 2));
            bus.req_strobe = 4'($urandom); bus.req_data = $urandom;
        end else begin
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic idleChecks();
        chk("arvalid_idle", 32'(bus.arvalid), 32'd0);
        chk("rready_idle", 32'(bus.rready), 32'd0);
        chk("awvalid_idle", 32'(bus.awvalid), 32'd0);
        chk("wvalid_idle", 32'(bus.wvalid), 32'd0);
        chk("bready_idle", 32'(bus.bready), 32'd0);
        chk("data_ok_idle", 32'(bus.data_ok), 32'd0);
        chk("addr_ok_idle", 32'(bus.addr_ok), 32'd0);
    endtask

    task automatic runTxn(input vec_t v, input vec_t nx, input bit pre,
                          output logic [31:0] gotData, output logic gotErr);
        bit isWr;
        bit done;
        bit awSeen;
        bit wSeen;
        isWr = (v.strobe != 4'b0000);
        if (!pre) begin
            tick(); driveReq(v); settle();
            chk("addr_ok_accept", 32'(bus.addr_ok), 32'd1);
        end
        if (!isWr) begin
            done = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                tick(); busyReq(v.chain); bus.arready = (c >= v.axDelay); settle();
                chk("arvalid", 32'(bus.arvalid), 32'd1);
                chk("araddr", bus.araddr, v.addr);
                chk("arsize", 32'(bus.arsize), 32'(v.expAxSize));
                chk("arid", 32'(bus.arid), 32'd1);
                chk("arlen", 32'(bus.arlen), 32'd0);
                chk("addr_ok_busy", 32'(bus.addr_ok), 32'd0);
                chk("data_ok_busy", 32'(bus.data_ok), 32'd0);
                done = bus.arvalid && bus.arready;
            end
            if (!done) chk("ar_timeout", 32'd0, 32'd1);
            done = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                tick(); busyReq(v.chain); bus.arready = 1'b0;
                bus.rvalid = (c >= v.respDelay); bus.rdata = v.rdata; bus.rresp = v.resp;
                settle();
                chk("rready", 32'(bus.rready), 32'd1);
                chk("arvalid_after_hs", 32'(bus.arvalid), 32'd0);
                chk("araddr_held", bus.araddr, v.addr);
                chk("addr_ok_busy", 32'(bus.addr_ok), 32'd0);
                chk("data_ok_busy", 32'(bus.data_ok), 32'd0);
                done = bus.rvalid && bus.rready;
            end
            if (!done) chk("r_timeout", 32'd0, 32'd1);
        end else begin
            awSeen = 1'b0;
            wSeen = 1'b0;
            for (int c = 0; c < 30 && !(awSeen && wSeen); c++) begin
                tick(); busyReq(v.chain);
                bus.awready = !awSeen && (c >= v.axDelay);
                bus.wready = !wSeen && (c >= v.wDelay);
                settle();
                chk("awvalid", 32'(bus.awvalid), 32'(!awSeen));
                chk("wvalid", 32'(bus.wvalid), 32'(!wSeen));
                chk("awaddr", bus.awaddr, v.addr);
                if (!awSeen) begin
                    chk("awsize", 32'(bus.awsize), 32'(v.expAxSize));
                    chk("awid", 32'(bus.awid), 32'd1);
                end
                if (!wSeen) begin
                    chk("wdata", bus.wdata, v.data);
                    chk("wstrb", 32'(bus.wstrb), 32'(v.strobe));
                    chk("wlast", 32'(bus.wlast), 32'd1);
                end
                chk("arvalid_wr", 32'(bus.arvalid), 32'd0);
                chk("addr_ok_busy", 32'(bus.addr_ok), 32'd0);
                chk("data_ok_busy", 32'(bus.data_ok), 32'd0);
                if (bus.awvalid && bus.awready) awSeen = 1'b1;
                if (bus.wvalid && bus.wready) wSeen = 1'b1;
            end
            if (!(awSeen && wSeen)) chk("aw_w_timeout", 32'd0, 32'd1);
            done = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                tick(); busyReq(v.chain); bus.awready = 1'b0; bus.wready = 1'b0;
                bus.bvalid = (c >= v.respDelay); bus.bresp = v.resp;
                settle();
                chk("bready", 32'(bus.bready), 32'd1);
                chk("awvalid_b", 32'(bus.awvalid), 32'd0);
                chk("wvalid_b", 32'(bus.wvalid), 32'd0);
                chk("awaddr_held", bus.awaddr, v.addr);
                chk("addr_ok_busy", 32'(bus.addr_ok), 32'd0);
                chk("data_ok_busy", 32'(bus.data_ok), 32'd0);
                done = bus.bvalid && bus.bready;
            end
            if (!done) chk("b_timeout", 32'd0, 32'd1);
        end
        tick(); axiIdle();
        if (v.chain) driveReq(nx); else bus.req_valid = 1'b0;
        settle();
        if (!isWr) modelData = v.rdata;
        chk("data_ok", 32'(bus.data_ok), 32'd1);
        chk("resp_data", bus.resp_data, modelData);
        chk("resp_err", 32'(bus.resp_err), 32'(v.resp != 2'b00));
        gotData = bus.resp_data;
        gotErr = bus.resp_err;
        if (v.chain) begin
            chk("addr_ok_b2b", 32'(bus.addr_ok), 32'd1);
        end else begin
            tick(); settle();
            chk("data_ok_pulse", 32'(bus.data_ok), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        vec_t cur;
        vec_t nx;
        logic [31:0] gd;
        logic ge;
        bit pre;

        //            addr          sz  strobe   data          ax w  r  rdata         resp  ch expData      err axsz
        tbl[0] = mkv(32'h1FD0_F010, 2, 4'b0000, 32'h0,        0, 0, 2, 32'hDEAD_BEEF, 2'b00, 0, 32'hDEAD_BEEF, 0, 3'd2);
        tbl[1] = mkv(32'h1FAF_0003, 0, 4'b1000, 32'h5A00_0000, 3, 0, 1, 32'h0,        2'b00, 0, 32'hDEAD_BEEF, 0, 3'd0);
        tbl[2] = mkv(32'h1FAF_0010, 1, 4'b0011, 32'h0000_1234, 1, 1, 0, 32'h0,        2'b10, 0, 32'hDEAD_BEEF, 1, 3'd1);
        tbl[3] = mkv(32'h1FD0_0002, 1, 4'b0000, 32'h0,        1, 0, 1, 32'h1234_5678, 2'b00, 1, 32'h1234_5678, 0, 3'd1);
        tbl[4] = mkv(32'h1FAF_0100, 2, 4'b1111, 32'hCAFE_F00D, 0, 2, 3, 32'h0,        2'b00, 1, 32'h1234_5678, 0, 3'd2);
        tbl[5] = mkv(32'h1FD0_0040, 3, 4'b0000, 32'h0,        2, 0, 0, 32'hA5A5_5A5A, 2'b11, 0, 32'hA5A5_5A5A, 1, 3'd3);

        axiIdle();
        bus.req_valid = 1'b0; bus.req_addr = 32'd0; bus.req_size = 2'd0;
        bus.req_strobe = 4'd0; bus.req_data = 32'd0;
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        settle();
        idleChecks();
        chk("reset_resp_data", bus.resp_data, 32'd0);
        chk("reset_resp_err", 32'(bus.resp_err), 32'd0);

        pre = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nx = (i < 5) ? tbl[i+1] : tbl[i];
            runTxn(tbl[i], nx, pre, gd, ge);
            chk($sformatf("tbl%0d_resp_data", i), gd, tbl[i].expData);
            chk($sformatf("tbl%0d_resp_err", i), 32'(ge), 32'(tbl[i].expErr));
            pre = tbl[i].chain;
        end

        // Reset while waiting for R: everything drops on the next cycle
        cur = tbl[0];
        tick(); driveReq(cur); settle();
        chk("rst_seq_addr_ok", 32'(bus.addr_ok), 32'd1);
        tick(); bus.req_valid = 1'b0; bus.arready = 1'b1; settle();
        chk("rst_seq_arvalid", 32'(bus.arvalid), 32'd1);
        tick(); bus.arready = 1'b0; settle();
        chk("rst_seq_rready", 32'(bus.rready), 32'd1);
        tick(); reset = 1'b1; settle();
        tick(); reset = 1'b0; settle();
        modelData = 32'd0;
        idleChecks();
        chk("rst_seq_resp_data", bus.resp_data, 32'd0);
        cur = tbl[3];
        cur.chain = 1'b0;
        runTxn(cur, cur, 1'b0, gd, ge);
        chk("post_reset_read", gd, 32'h1234_5678);

        cur = genRand();
        pre = 1'b0;
        for (int i = 0; i < 40; i++) begin
            nx = genRand();
            cur.chain = (i < 39) && ($urandom_range(0, 3) == 0);
            runTxn(cur, nx, pre, gd, ge);
            pre = cur.chain;
            cur = nx;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
